// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball sequencer: steps the ball each frame, hands the new
// position to the collision checker, then applies its bounce/miss verdict.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | ball parked at serve position, waiting for Serve
//  RUN     | in play, waiting for the next FrameTick to step the ball
//  WAIT    | coords stable, collision checker settling (COL_LAT cycles)
//  RESOLVE | sample ColIn once and apply bounce / hit / miss
//  OVER    | miss limit reached, frozen until reset
module ball_motion_ctrl #(
    parameter int STEP       = 2,
    parameter int SERVE_X    = 320,
    parameter int SERVE_Y    = 200,
    parameter int COL_LAT    = 2,
    parameter int MAX_MISSES = 5
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       FrameTick,
    input  logic       Serve,
    input  logic [2:0] ColIn,
    output logic [9:0] XCord,
    output logic [9:0] YCord,
    output logic       CordValid,
    output logic       InPlay,
    output logic [7:0] Hits,
    output logic [3:0] Misses,
    output logic       Miss,
    output logic       Overrun,
    output logic       GameOver
);

    localparam int CW = $clog2(COL_LAT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        WAIT    = 3'd2,
        RESOLVE = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t         state, stateNext;
    logic   [CW-1:0] colCnt, colCntNext;
    logic           dirX, dirXNext;
    logic           dirY, dirYNext;
    logic   [9:0]   xNext, yNext;
    logic   [7:0]   hitsNext;
    logic   [3:0]   missesNext;
    logic           missNext, overrunNext;

    // One axis step; clamps at the edges of the 10-bit range instead of wrapping.
    function automatic logic [9:0] stepAxis(input logic [9:0] pos, input logic dir);
        logic [10:0] sum;
        sum = {1'b0, pos} + 11'(STEP);
        if (dir)
            return (sum > 11'd1023) ? 10'd1023 : sum[9:0];
        else
            return (pos < 10'(STEP)) ? 10'd0 : pos - 10'(STEP);
    endfunction

    // Next-state, datapath and pulse outputs.
    always_comb begin
        stateNext   = state;
        colCntNext  = colCnt;
        dirXNext    = dirX;
        dirYNext    = dirY;
        xNext       = XCord;
        yNext       = YCord;
        hitsNext    = Hits;
        missesNext  = Misses;
        missNext    = 1'b0;
        overrunNext = 1'b0;
        case (state)
            IDLE: begin
                if (Serve) stateNext = RUN;
            end
            RUN: begin
                if (FrameTick) begin
                    xNext      = stepAxis(XCord, dirX);
                    yNext      = stepAxis(YCord, dirY);
                    colCntNext = CW'(COL_LAT);
                    stateNext  = WAIT;
                end
            end
            WAIT: begin
                overrunNext = FrameTick;
                if (colCnt == CW'(1)) stateNext = RESOLVE;
                else                  colCntNext = colCnt - CW'(1);
            end
            RESOLVE: begin
                overrunNext = FrameTick;
                stateNext   = RUN;
                case (ColIn)
                    3'b001: begin
                        // Only the first paddle contact of a return counts.
                        if (dirX) begin
                            dirXNext = 1'b0;
                            if (Hits != 8'hFF) hitsNext = Hits + 8'd1;
                        end
                    end
                    3'b010: dirYNext = 1'b1;
                    3'b110: dirYNext = 1'b0;
                    3'b100: dirXNext = 1'b1;
                    3'b011: begin
                        missNext = 1'b1;
                        if (Misses < 4'(MAX_MISSES)) missesNext = Misses + 4'd1;
                        xNext     = 10'(SERVE_X);
                        yNext     = 10'(SERVE_Y);
                        dirXNext  = 1'b1;
                        dirYNext  = 1'b1;
                        stateNext = (missesNext == 4'(MAX_MISSES)) ? OVER : IDLE;
                    end
                    default: ;
                endcase
            end
            OVER: ;
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            colCnt  <= '0;
            dirX    <= 1'b1;
            dirY    <= 1'b1;
            XCord   <= 10'(SERVE_X);
            YCord   <= 10'(SERVE_Y);
            Hits    <= 8'd0;
            Misses  <= 4'd0;
            Miss    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state   <= stateNext;
            colCnt  <= colCntNext;
            dirX    <= dirXNext;
            dirY    <= dirYNext;
            XCord   <= xNext;
            YCord   <= yNext;
            Hits    <= hitsNext;
            Misses  <= missesNext;
            Miss    <= missNext;
            Overrun <= overrunNext;
        end
    end

    assign CordValid = (state == WAIT);
    assign InPlay    = (state == RUN) || (state == WAIT) || (state == RESOLVE);
    assign GameOver  = (state == OVER);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with default parameters.
module tb_ball_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       FrameTick = 1'b0;
    logic       Serve = 1'b0;
    logic [2:0] ColIn = 3'b000;
    logic [9:0] XCord, YCord;
    logic       CordValid, InPlay, Miss, Overrun, GameOver;
    logic [7:0] Hits;
    logic [3:0] Misses;

    int checks = 0;
    int errors = 0;

    ball_motion_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .FrameTick(FrameTick), .Serve(Serve), .ColIn(ColIn),
        .XCord(XCord), .YCord(YCord), .CordValid(CordValid), .InPlay(InPlay),
        .Hits(Hits), .Misses(Misses), .Miss(Miss), .Overrun(Overrun), .GameOver(GameOver)
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full frame: tick in RUN, two WAIT cycles, RESOLVE with ColIn, back to RUN.
    task automatic frame(input logic [2:0] col);
        ColIn     = col;
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        cyc();
        cyc();
        cyc();
        ColIn = 3'b000;
    endtask

    task automatic doServe();
        Serve = 1'b1;
        cyc();
        Serve = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_x", 32'(XCord), 320);
        chk("rst_y", 32'(YCord), 200);
        chk("rst_hits", 32'(Hits), 0);
        chk("rst_misses", 32'(Misses), 0);
        chk("rst_flags", {27'd0, Miss, Overrun, CordValid, InPlay, GameOver}, 0);
        Rst_n = 1'b1;
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        chk("idle_tick_ignored", {28'd0, CordValid, InPlay, Overrun, 1'b0}, 0);
        chk("idle_x", 32'(XCord), 320);

        // T1: serve, one frame with no collision
        doServe();
        chk("t1_inplay", 32'(InPlay), 1);
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        chk("t1_x", 32'(XCord), 322);
        chk("t1_y", 32'(YCord), 202);
        chk("t1_cv1", 32'(CordValid), 1);
        cyc();
        chk("t1_cv2", 32'(CordValid), 1);
        cyc();
        chk("t1_cv_resolve", {30'd0, CordValid, InPlay}, 1);
        cyc();
        FrameTick = 1'b1;  // back in RUN at n+4: this tick must be taken
        cyc();
        FrameTick = 1'b0;
        chk("t1_rerun_cv", 32'(CordValid), 1);
        chk("t1_rerun_ovr", 32'(Overrun), 0);
        chk("t1_rerun_x", 32'(XCord), 324);
        chk("t1_rerun_y", 32'(YCord), 204);
        cyc(); cyc(); cyc();

        // T2: paddle return and double-count protection
        frame(3'b001);
        chk("t2_x", 32'(XCord), 326);
        chk("t2_hits1", 32'(Hits), 1);
        frame(3'b000);
        chk("t2_x_left", 32'(XCord), 324);
        chk("t2_y", 32'(YCord), 208);
        frame(3'b001);
        chk("t2_hits_dup", 32'(Hits), 1);
        chk("t2_x2", 32'(XCord), 322);
        frame(3'b100);
        chk("t2_wall_x", 32'(XCord), 320);
        frame(3'b000);
        chk("t2_right_again", 32'(XCord), 322);
        chk("t2_y2", 32'(YCord), 214);

        // T3: ceiling then floor
        frame(3'b010);
        chk("t3_y_ceil", 32'(YCord), 216);
        frame(3'b110);
        chk("t3_y_floor", 32'(YCord), 218);
        frame(3'b000);
        chk("t3_y_up", 32'(YCord), 216);
        frame(3'b010);
        chk("t3_y_up2", 32'(YCord), 214);
        frame(3'b000);
        chk("t3_y_down", 32'(YCord), 216);
        chk("t3_x", 32'(XCord), 332);

        // T4: five misses end the game
        for (int i = 1; i <= 5; i++) begin
            doServe();
            frame(3'b011);
            chk($sformatf("t4_miss_pulse%0d", i), 32'(Miss), 1);
            chk($sformatf("t4_misses%0d", i), 32'(Misses), i);
            chk($sformatf("t4_pos%0d", i), {12'd0, XCord, YCord}, {12'd0, 10'd320, 10'd200});
            cyc();
            chk($sformatf("t4_miss_clr%0d", i), 32'(Miss), 0);
        end
        chk("t4_gameover", {30'd0, GameOver, InPlay}, 2);
        doServe();
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        cyc();
        chk("t4_frozen", {27'd0, GameOver, InPlay, CordValid, Overrun, Miss}, 16);
        chk("t4_frozen_pos", {12'd0, XCord, YCord}, {12'd0, 10'd320, 10'd200});

        // T5: saturation at both ends and dropped ticks
        Rst_n = 1'b0;
        cyc();
        Rst_n = 1'b1;
        chk("t5_reset_misses", 32'(Misses), 0);
        doServe();
        for (int i = 0; i < 412; i++) frame(3'b000);
        chk("t5_y_top", 32'(YCord), 1023);
        chk("t5_x_top", 32'(XCord), 1023);
        frame(3'b110);
        chk("t5_y_top_hold", 32'(YCord), 1023);
        for (int i = 0; i < 511; i++) frame(3'b000);
        chk("t5_y_one", 32'(YCord), 1);
        FrameTick = 1'b1;
        cyc();
        chk("t5_ovr_not_yet", 32'(Overrun), 0);
        cyc();  // tick still high during WAIT
        FrameTick = 1'b0;
        chk("t5_overrun_wait", 32'(Overrun), 1);
        chk("t5_y_zero", 32'(YCord), 0);
        chk("t5_cv_during", 32'(CordValid), 1);
        cyc();
        chk("t5_ovr_clear", 32'(Overrun), 0);
        cyc();
        frame(3'b010);
        chk("t5_y_zero_hold", 32'(YCord), 0);
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        cyc();
        cyc();
        FrameTick = 1'b1;  // tick during RESOLVE
        cyc();
        FrameTick = 1'b0;
        chk("t5_overrun_resolve", 32'(Overrun), 1);
        chk("t5_y_once", 32'(YCord), 2);
        chk("t5_no_restart", 32'(CordValid), 0);

        // T6: reset in WAIT with Hits=3
        frame(3'b001);
        frame(3'b100);
        frame(3'b001);
        frame(3'b100);
        frame(3'b001);
        chk("t6_hits3", 32'(Hits), 3);
        FrameTick = 1'b1;
        cyc();
        FrameTick = 1'b0;
        chk("t6_in_wait", 32'(CordValid), 1);
        Rst_n = 1'b0;
        cyc();
        Rst_n = 1'b1;
        chk("t6_cv", 32'(CordValid), 0);
        chk("t6_x", 32'(XCord), 320);
        chk("t6_hits", 32'(Hits), 0);
        chk("t6_inplay", 32'(InPlay), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
